cla_adder: RTL and testbench

- Parameterised unsigned N-bit carry-lookahead adder with a registered (N+1)-bit sum; carry-out is the MSB of the sum.
- Arithmetic leaf block for datapaths that need a fast, wide add with one cycle of latency.
- Single clock domain; synchronous, active-low reset.

---
 rtl/cla_pkg.sv | 15 +
 rtl/cla_group4.sv | 31 +++
 rtl/cla_adder.sv | 90 +++++++++
 tb/tb_cla_adder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared sizing helpers for the carry-lookahead adder.
// Groups are 4 bits; blocks are 4 groups (16 bits).
package cla_pkg;

  localparam int GROUP_W = 4;

  function automatic int num_groups(input int n);
    return (n + GROUP_W - 1) / GROUP_W;
  endfunction

  function automatic int num_blocks(input int n);
    return (num_groups(n) + GROUP_W - 1) / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-wide lookahead cell: internal carries plus group G/P.
// Used both on bit-level and on group-level g/p.
module cla_group4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       c_in,
  output logic [2:0] carry,
  output logic       grp_g,
  output logic       grp_p
);

  assign carry[0] = g[0]
                  | (p[0] & c_in);

  assign carry[1] = g[1]
                  | (p[1] & g[0])
                  | (p[1] & p[0] & c_in);

  assign carry[2] = g[2]
                  | (p[2] & g[1])
                  | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c_in);

  assign grp_g = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

  assign grp_p = &p;

endmodule

// File: rtl/cla_adder.sv
// Unsigned N-bit carry-lookahead adder, registered (N+1)-bit sum.
// Two-level lookahead inside 16-bit blocks, block-to-block ripple.
module cla_adder
  import cla_pkg::*;
#(
  parameter int N       = 3,
  parameter int GROUP_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   sum,
  output logic         out_valid
);

  localparam int NG = num_groups(N);
  localparam int NB = num_blocks(N);
  localparam int W  = NG * GROUP_W;

  logic [W-1:0]    ax;
  logic [W-1:0]    bx;
  logic [W-1:0]    g;
  logic [W-1:0]    p;
  logic [W:0]      c;
  logic [W:0]      s_full;
  logic [NB*4:0]   gc;
  logic [NB*4-1:0] grp_g;
  logic [NB*4-1:0] grp_p;
  logic [NB-1:0]   blk_g;
  logic [NB-1:0]   blk_p;
  logic            unused;

  // Zero padding kills any carry entering the pad bits.
  assign ax = W'(a);
  assign bx = W'(b);
  assign g  = ax & bx;
  assign p  = ax ^ bx;

  assign gc[0] = 1'b0;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    cla_group4 u_grp (
      .g     (g[4*j +: 4]),
      .p     (p[4*j +: 4]),
      .c_in  (gc[j]),
      .carry (c[4*j+1 +: 3]),
      .grp_g (grp_g[j]),
      .grp_p (grp_p[j])
    );
    assign c[4*j] = gc[j];
  end

  for (genvar j = NG; j < NB*4; j++) begin : g_pad
    assign grp_g[j] = 1'b0;
    assign grp_p[j] = 1'b0;
  end

  for (genvar k = 0; k < NB; k++) begin : g_blk
    cla_group4 u_blk (
      .g     (grp_g[4*k +: 4]),
      .p     (grp_p[4*k +: 4]),
      .c_in  (gc[4*k]),
      .carry (gc[4*k+1 +: 3]),
      .grp_g (blk_g[k]),
      .grp_p (blk_p[k])
    );
    assign gc[4*k+4] = blk_g[k]
                     | (blk_p[k] & gc[4*k]);
  end

  assign c[W]   = gc[NG];
  assign s_full = {c[W], p ^ c[W-1:0]};

  assign unused = ^{s_full, gc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum <= s_full[N:0];
      end
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench: four widths against an arithmetic model.
// Directed literals pin the model; random traffic checks the rest.
module tb_cla_adder;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;

  logic [2:0]  a3,  b3;
  logic [3:0]  sum3;
  logic        ov3;
  logic [15:0] a16, b16;
  logic [16:0] sum16;
  logic        ov16;
  logic [5:0]  a6,  b6;
  logic [6:0]  sum6;
  logic        ov6;
  logic [36:0] a37, b37;
  logic [37:0] sum37;
  logic        ov37;

  logic [3:0]  m3;
  logic [16:0] m16;
  logic [6:0]  m6;
  logic [37:0] m37;
  logic        mv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_adder #(.N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a3), .b(b3), .sum(sum3), .out_valid(ov3)
  );
  cla_adder #(.N(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a16), .b(b16), .sum(sum16), .out_valid(ov16)
  );
  cla_adder #(.N(6)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a6), .b(b6), .sum(sum6), .out_valid(ov6)
  );
  cla_adder #(.N(37)) u37 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a37), .b(b37), .sum(sum37), .out_valid(ov37)
  );

  // Reference: result of the last accepted pair, cleared by reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      m3 <= '0; m16 <= '0; m6 <= '0; m37 <= '0;
      mv <= 1'b0;
    end else if (in_valid) begin
      m3  <= 4'(a3)   + 4'(b3);
      m16 <= 17'(a16) + 17'(b16);
      m6  <= 7'(a6)   + 7'(b6);
      m37 <= 38'(a37) + 38'(b37);
      mv  <= 1'b1;
    end else begin
      mv <= 1'b0;
    end
  end

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_all();
    check("ov3",   64'(ov3),   64'(mv));
    check("sum3",  64'(sum3),  64'(m3));
    check("ov16",  64'(ov16),  64'(mv));
    check("sum16", 64'(sum16), 64'(m16));
    check("ov6",   64'(ov6),   64'(mv));
    check("sum6",  64'(sum6),  64'(m6));
    check("ov37",  64'(ov37),  64'(mv));
    check("sum37", 64'(sum37), 64'(m37));
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [2:0]  x3,  input logic [2:0]  y3,
                       input logic [15:0] x16, input logic [15:0] y16,
                       input logic [5:0]  x6,  input logic [5:0]  y6);
    a3 = x3;   b3 = y3;
    a16 = x16; b16 = y16;
    a6 = x6;   b6 = y6;
    a37 = {$urandom, $urandom};
    b37 = {$urandom, $urandom};
  endtask

  task automatic rand_ops();
    a3 = 3'($urandom);   b3 = 3'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom);
    a6 = 6'($urandom);   b6 = 6'($urandom);
    a37 = 37'({$urandom, $urandom});
    b37 = 37'({$urandom, $urandom});
    if ($urandom_range(0, 7) == 0) begin
      a37 = '1; a16 = '1; a6 = '1; a3 = '1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    check("rst_sum3", 64'(sum3), 64'h0);
    check("rst_ov3",  64'(ov3),  64'h0);

    rst_n = 1'b1;
    in_valid = 1'b1;
    drive(3'd0, 3'd1, 16'hFFFF, 16'h0001, 6'd63, 6'd63);
    cyc();
    check("lit_0p1",    64'(sum3),  64'h1);
    check("lit_ov",     64'(ov3),   64'h1);
    check("lit_ffff",   64'(sum16), 64'h10000);
    check("lit_63p63",  64'(sum6),  64'd126);

    drive(3'd2, 3'd2, 16'h00FF, 16'h0001, 6'd32, 6'd32);
    cyc();
    check("lit_2p2",    64'(sum3),  64'h4);
    check("lit_00ff",   64'(sum16), 64'h00100);
    check("lit_32p32",  64'(sum6),  64'd64);

    drive(3'd5, 3'd6, 16'h1234, 16'h4321, 6'd1, 6'd2);
    cyc();
    check("lit_5p6",    64'(sum3),  64'hB);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 3'd1, 16'h1, 16'h1, 6'd1, 6'd1);
      cyc();
      check("hold_sum3", 64'(sum3), 64'hB);
      check("hold_ov3",  64'(ov3),  64'h0);
    end

    in_valid = 1'b1;
    drive(3'd7, 3'd7, 16'h8000, 16'h8000, 6'd0, 6'd0);
    cyc();
    check("lit_7p7",    64'(sum3),  64'hE);

    rst_n = 1'b0;
    drive(3'd7, 3'd7, 16'hFFFF, 16'hFFFF, 6'd63, 6'd63);
    cyc();
    check("midrst_sum3", 64'(sum3), 64'h0);
    check("midrst_ov3",  64'(ov3),  64'h0);
    rst_n = 1'b1;
    drive(3'd5, 3'd6, 16'h0, 16'h0, 6'd0, 6'd0);
    cyc();
    check("post_rst_sum3", 64'(sum3), 64'hB);
    check("post_rst_ov3",  64'(ov3),  64'h1);

    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rand_ops();
      cyc();
    end
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom);
      rand_ops();
      cyc();
    end
    in_valid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
